// File: rtl/fwrisc_fetch_pkg.sv
// Shared constants and helpers for the prefetching fetch unit and its halfword queue.
package fwrisc_fetch_pkg;

  // Low two opcode bits that mark a full 32-bit instruction.
  localparam logic [1:0]  OPC_32_LOW = 2'b11;

  localparam logic [31:0] PC_INC_C   = 32'd2;
  localparam logic [31:0] PC_INC_W   = 32'd4;

  function automatic logic is_compressed(input logic [15:0] hw, input logic enable);
    return enable && (hw[1:0] != OPC_32_LOW);
  endfunction

endpackage

// File: rtl/fwrisc_hw_queue.sv
// Circular halfword queue: accepts one or two halfwords per cycle, releases one or two,
// and exposes the two oldest entries for instruction assembly.
module fwrisc_hw_queue #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push1,
  input  logic          push2,
  input  logic [15:0]   push_hw0,
  input  logic [15:0]   push_hw1,
  input  logic          pop1,
  input  logic          pop2,
  output logic [CW-1:0] count,
  output logic [15:0]   peek0,
  output logic [15:0]   peek1
);

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    push_n, pop_n;

  // Advance a pointer by 0..2 with wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [1:0] n);
    logic [PW:0] sum;
    sum = {1'b0, ptr} + {{(PW-1){1'b0}}, n};
    if (sum >= (PW+1)'(DEPTH)) sum = sum - (PW+1)'(DEPTH);
    return sum[PW-1:0];
  endfunction

  always_comb begin
    // NOTE: every output of this block is assigned up front so no path leaves a latch behind.
    push_n   = push2 ? 2'd2 : {1'b0, push1};
    pop_n    = pop2  ? 2'd2 : {1'b0, pop1};
    wr_ptr_d = ptr_add(wr_ptr_q, push_n);
    rd_ptr_d = ptr_add(rd_ptr_q, pop_n);
    count_d  = count_q + CW'(push_n) - CW'(pop_n);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of order.
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; an entry is only ever read once count says it was written.
  always_ff @(posedge clock) begin
    if (!flush && (push1 || push2)) mem_q[wr_ptr_q] <= push_hw0;
    if (!flush && push2)            mem_q[ptr_add(wr_ptr_q, 2'd1)] <= push_hw1;
  end

  assign count = count_q;
  assign peek0 = mem_q[rd_ptr_q];
  assign peek1 = mem_q[ptr_add(rd_ptr_q, 2'd1)];

endmodule

// File: rtl/fwrisc_fetch_pq.sv
// Prefetching fetch unit: streams sequential words into a halfword queue and presents one
// assembled 16/32-bit instruction at a time to decode; a redirect flushes and restarts.
module fwrisc_fetch_pq
  import fwrisc_fetch_pkg::*;
#(
  parameter bit          ENABLE_COMPRESSED = 1'b1,
  parameter int          QUEUE_DEPTH       = 8,
  parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] iaddr,
  output logic        ivalid,
  input  logic [31:0] idata,
  input  logic        iready,
  output logic        fetch_valid,
  input  logic        decode_complete,
  output logic [31:0] instr,
  output logic        instr_c,
  output logic [31:0] instr_pc
);

  localparam int          CW         = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW:0] ROOM_LIMIT = (CW+1)'(QUEUE_DEPTH - 2);

  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic          skip_lo_q, skip_lo_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic          run_q, run_d;

  logic [CW-1:0] q_count;
  logic [15:0]   hw0, hw1, push_hw0;
  logic          head_c, consume, pop1, pop2, xfer, push1, push2;
  logic [1:0]    pop_cnt;
  logic [CW:0]   room_limit;
  logic          unused_pc_bit;

  assign unused_pc_bit = redirect_pc[0];

  fwrisc_hw_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (redirect),
    .push1    (push1),
    .push2    (push2),
    .push_hw0 (push_hw0),
    .push_hw1 (idata[31:16]),
    .pop1     (pop1),
    .pop2     (pop2),
    .count    (q_count),
    .peek0    (hw0),
    .peek1    (hw1)
  );

  always_comb begin
    head_c      = is_compressed(hw0, ENABLE_COMPRESSED);
    fetch_valid = head_c ? (q_count >= CW'(1)) : (q_count >= CW'(2));
    instr       = 32'h0;
    instr_c     = 1'b0;
    if (fetch_valid) begin
      instr   = head_c ? {16'h0, hw0} : {hw1, hw0};
      instr_c = head_c;
    end

    consume = decode_complete && fetch_valid && !redirect;
    pop1    = consume && head_c;
    pop2    = consume && !head_c;
    pop_cnt = pop2 ? 2'd2 : {1'b0, pop1};

    // Request only when a full word still fits after this cycle's pop; run_q keeps the bus
    // quiet for the first cycle after reset release.
    room_limit = ROOM_LIMIT + {{(CW-1){1'b0}}, pop_cnt};
    ivalid     = run_q && !redirect && ({1'b0, q_count} <= room_limit);
    xfer       = ivalid && iready;
    push1      = xfer && skip_lo_q;
    push2      = xfer && !skip_lo_q;
    push_hw0   = skip_lo_q ? idata[31:16] : idata[15:0];
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    skip_lo_d    = skip_lo_q;
    head_pc_d    = head_pc_q;
    run_d        = 1'b1;
    if (redirect) begin
      fetch_addr_d = {redirect_pc[31:2], 2'b00};
      skip_lo_d    = redirect_pc[1];
      head_pc_d    = {redirect_pc[31:1], 1'b0};
    end else begin
      if (xfer) begin
        fetch_addr_d = fetch_addr_q + PC_INC_W;
        skip_lo_d    = 1'b0;
      end
      if (pop1)      head_pc_d = head_pc_q + PC_INC_C;
      else if (pop2) head_pc_d = head_pc_q + PC_INC_W;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr_q <= {RESET_VECTOR[31:2], 2'b00};
      skip_lo_q    <= RESET_VECTOR[1];
      head_pc_q    <= RESET_VECTOR;
      run_q        <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      skip_lo_q    <= skip_lo_d;
      head_pc_q    <= head_pc_d;
      run_q        <= run_d;
    end
  end

  assign iaddr    = fetch_addr_q;
  assign instr_pc = head_pc_q;

endmodule
